// File: rtl/cdf_pkg.sv
// cdf_pkg: shared constants, state encoding and group derivation for the CDF controller/datapath
package cdf_pkg;
    localparam int BINS_PER_WORD   = 4;
    localparam int WORDS_PER_GROUP = 2;
    localparam int BINS_PER_GROUP  = BINS_PER_WORD * WORDS_PER_GROUP;

    typedef enum logic [2:0] {
        IDLE, START, READ, WAIT, LOAD, WR_LO, WR_HI, DONE
    } cdf_state_t;

    function automatic int num_groups(input int num_bins);
        return num_bins / BINS_PER_GROUP;
    endfunction
endpackage

// File: rtl/cdf_controller.sv
// cdf_controller: sequences cdf_datapath over the histogram and writes the CDF back to scratch memory
module cdf_controller
    import cdf_pkg::*;
#(
    parameter int NUM_BINS  = 256,
    parameter int ADDR_W    = 8,
    parameter int HIST_BASE = 0,
    parameter int CDF_BASE  = 64,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              histogram_done,
    output logic              scratchmem_rd_en,
    output logic [ADDR_W-1:0] scratchmem_rd_addr1,
    output logic [ADDR_W-1:0] scratchmem_rd_addr2,
    output logic              scratchmem_wr_en,
    output logic [ADDR_W-1:0] scratchmem_wr_addr,
    output logic              dp_clear,
    output logic              dp_load,
    output logic              dp_out_sel,
    output logic              cdf_done
);
    localparam int NG = num_groups(NUM_BINS);
    localparam int GW = NG > 1 ? $clog2(NG) : 1;
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT > 0 ? RD_LAT - 1 : 0);
    localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

    cdf_state_t state, state_nx;
    logic [GW-1:0] g;
    logic [2:0] lat;
    logic [ADDR_W-1:0] g2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            g     <= '0;
            lat   <= '0;
        end else begin
            state <= state_nx;
            g     <= state == START ? '0 : (state == WR_HI && g != G_LAST) ? g + GW'(1) : g;
            lat   <= state == WAIT ? lat + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = histogram_done ? START : IDLE;
            START:   state_nx = READ;
            READ:    state_nx = RD_LAT > 0 ? WAIT : LOAD;
            WAIT:    state_nx = lat == LAT_LAST ? LOAD : WAIT;
            LOAD:    state_nx = WR_LO;
            WR_LO:   state_nx = WR_HI;
            WR_HI:   state_nx = g == G_LAST ? DONE : READ;
            DONE:    state_nx = histogram_done ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
        // dropping histogram_done mid-run abandons the pass
        if (!histogram_done && state != IDLE && state != DONE)
            state_nx = IDLE;
    end

    assign g2                  = ADDR_W'({g, 1'b0});
    assign scratchmem_rd_en    = state == READ;
    assign scratchmem_rd_addr1 = scratchmem_rd_en ? ADDR_W'(HIST_BASE) + g2 : '0;
    assign scratchmem_rd_addr2 = scratchmem_rd_en ? ADDR_W'(HIST_BASE) + g2 + ADDR_W'(1) : '0;
    assign scratchmem_wr_en    = state == WR_LO || state == WR_HI;
    assign dp_out_sel          = state == WR_HI;
    assign scratchmem_wr_addr  = scratchmem_wr_en ? ADDR_W'(CDF_BASE) + g2 + (dp_out_sel ? ADDR_W'(1) : '0) : '0;
    assign dp_clear            = state == START;
    assign dp_load             = state == LOAD;
    assign cdf_done            = state == DONE;
endmodule
